// File: rtl/datapath_if.sv
// Controller-to-datapath strobe/data bundle plus the exported bus.
// DATAPATH_CARRY_EN adds the carry_out flag.
interface datapath_if;
  logic [1:0] op;
  logic [5:0] reg_sig;
  logic       data_in;
  logic [2:0] data;
  logic       A_in;
  logic       G_in;
  logic       G_out;
  logic [2:0] bus_output;
`ifdef DATAPATH_CARRY_EN
  logic       carry_out;

  modport master (
    output op, reg_sig, data_in, data, A_in, G_in, G_out,
    input  bus_output, carry_out
  );

  modport slave (
    input  op, reg_sig, data_in, data, A_in, G_in, G_out,
    output bus_output, carry_out
  );
`else
  modport master (
    output op, reg_sig, data_in, data, A_in, G_in, G_out,
    input  bus_output
  );

  modport slave (
    input  op, reg_sig, data_in, data, A_in, G_in, G_out,
    output bus_output
  );
`endif
endinterface

// File: rtl/datapath.sv
// Three-bit single-bus datapath: R0-R2, ALU operand A and result G on a priority-mux bus.
// Defining DATAPATH_CARRY_EN adds the carry/borrow flag C and the carry_out output.
module datapath (
  input logic       clk,
  input logic       rst,
  datapath_if.slave dp
);

  logic [2:0] r0_q, r1_q, r2_q, a_q, g_q;
  logic [2:0] r0_d, r1_d, r2_d, a_d, g_d;
  logic [2:0] bus;
  logic [3:0] alu_res;

  // Priority mux stands in for a tri-state bus.
  always_comb begin
    if (dp.data_in) begin
      bus = dp.data;
    end else if (dp.G_out) begin
      bus = g_q;
    end else if (dp.reg_sig[4]) begin
      bus = r0_q;
    end else if (dp.reg_sig[2]) begin
      bus = r1_q;
    end else if (dp.reg_sig[0]) begin
      bus = r2_q;
    end else begin
      bus = 3'b000;
    end
  end

  assign dp.bus_output = bus;

  // Bit 3 holds carry (add) or borrow (subtract); logic ops leave it clear.
  always_comb begin
    alu_res = 4'b0000;
    case (dp.op)
      2'b00:   alu_res = {1'b0, a_q} + {1'b0, bus};
      2'b01:   alu_res = {1'b0, a_q} - {1'b0, bus};
      2'b10:   alu_res = {1'b0, a_q & bus};
      default: alu_res = {1'b0, a_q | bus};
    endcase
  end

  always_comb begin
    r0_d = dp.reg_sig[5] ? bus : r0_q;
    r1_d = dp.reg_sig[3] ? bus : r1_q;
    r2_d = dp.reg_sig[1] ? bus : r2_q;
    a_d  = dp.A_in ? bus : a_q;
    g_d  = dp.G_in ? alu_res[2:0] : g_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r0_q <= 3'b000;
      r1_q <= 3'b000;
      r2_q <= 3'b000;
      a_q  <= 3'b000;
      g_q  <= 3'b000;
    end else begin
      r0_q <= r0_d;
      r1_q <= r1_d;
      r2_q <= r2_d;
      a_q  <= a_d;
      g_q  <= g_d;
    end
  end

`ifdef DATAPATH_CARRY_EN
  logic c_q, c_d;

  assign c_d = dp.G_in ? alu_res[3] : c_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      c_q <= 1'b0;
    end else begin
      c_q <= c_d;
    end
  end

  assign dp.carry_out = c_q;
`else
  logic unused_carry;
  assign unused_carry = alu_res[3];
`endif

endmodule

// File: tb/tb_datapath.sv
// Directed plus randomized bench for datapath against an arithmetic reference model.
// Carry checks are compiled in when DATAPATH_CARRY_EN is defined.
module tb_datapath;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   vectors = 0;
  int   errs = 0;

  datapath_if dp_if ();

  datapath dut (
    .clk (clk),
    .rst (rst),
    .dp  (dp_if)
  );

  always #5 clk = ~clk;

  // Reference state: plain integers, updated once per rising edge.
  int m_r [3];
  int m_a;
  int m_g;
  int m_c;

  function automatic int model_bus();
    if (dp_if.data_in)         return int'(dp_if.data);
    else if (dp_if.G_out)      return m_g;
    else if (dp_if.reg_sig[4]) return m_r[0];
    else if (dp_if.reg_sig[2]) return m_r[1];
    else if (dp_if.reg_sig[0]) return m_r[2];
    return 0;
  endfunction

  task automatic check(input string tag, input logic [2:0] obs, input int expv);
    logic [2:0] e;
    e = 3'(expv);
    vectors++;
    assert (obs === e) else begin
      errs++;
      $error("FAIL %s: observed %b expected %b", tag, obs, e);
    end
  endtask

  task automatic check_carry(input string tag);
`ifdef DATAPATH_CARRY_EN
    logic e;
    e = (m_c != 0);
    vectors++;
    assert (dp_if.carry_out === e) else begin
      errs++;
      $error("FAIL %s: carry observed %b expected %b", tag, dp_if.carry_out, e);
    end
`else
    if (tag.len() < 0) $display("%s", tag);
`endif
  endtask

  // Apply inputs after the falling edge, then check the combinational bus.
  task automatic drive(input string tag, input logic r, input logic [1:0] o,
                       input logic [5:0] rs, input logic di, input logic [2:0] d,
                       input logic ai, input logic gi, input logic go);
    @(negedge clk);
    rst = r;
    dp_if.op = o;
    dp_if.reg_sig = rs;
    dp_if.data_in = di;
    dp_if.data = d;
    dp_if.A_in = ai;
    dp_if.G_in = gi;
    dp_if.G_out = go;
    #1;
    check(tag, dp_if.bus_output, model_bus());
    check_carry(tag);
  endtask

  task automatic tick();
    int b, ng, nc;
    b = model_bus();
    ng = m_g;
    nc = m_c;
    if (dp_if.G_in) begin
      case (dp_if.op)
        2'b00: begin ng = (m_a + b) % 8; nc = (m_a + b > 7) ? 1 : 0; end
        2'b01: begin ng = (m_a - b + 8) % 8; nc = (m_a < b) ? 1 : 0; end
        2'b10: begin ng = m_a & b; nc = 0; end
        default: begin ng = m_a | b; nc = 0; end
      endcase
    end
    @(posedge clk);
    if (rst) begin
      m_r[0] = 0; m_r[1] = 0; m_r[2] = 0; m_a = 0; m_g = 0; m_c = 0;
    end else begin
      if (dp_if.reg_sig[5]) m_r[0] = b;
      if (dp_if.reg_sig[3]) m_r[1] = b;
      if (dp_if.reg_sig[1]) m_r[2] = b;
      if (dp_if.A_in) m_a = b;
      m_g = ng;
      m_c = nc;
    end
  endtask

  initial begin
    m_r[0] = 0; m_r[1] = 0; m_r[2] = 0; m_a = 0; m_g = 0; m_c = 0;
    dp_if.op = 2'b00; dp_if.reg_sig = 6'b0; dp_if.data_in = 1'b0; dp_if.data = 3'b0;
    dp_if.A_in = 1'b0; dp_if.G_in = 1'b0; dp_if.G_out = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);

    // Reset state: every register reads back 000.
    drive("rst_idle", 1'b1, 2'b00, 6'b000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0); tick();
    drive("rst_r0", 1'b0, 2'b00, 6'b010000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    check("rst_r0_lit", dp_if.bus_output, 0); tick();
    drive("rst_g", 1'b0, 2'b00, 6'b000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    check("rst_g_lit", dp_if.bus_output, 0); tick();

    // Load and display.
    drive("ld_r1", 1'b0, 2'b00, 6'b001000, 1'b1, 3'b010, 1'b0, 1'b0, 1'b0); tick();
    drive("ld_r0", 1'b0, 2'b00, 6'b100000, 1'b1, 3'b111, 1'b0, 1'b0, 1'b0); tick();
    drive("show_r1", 1'b0, 2'b00, 6'b000100, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    check("show_r1_lit", dp_if.bus_output, 3'b010); tick();
    drive("show_r0", 1'b0, 2'b00, 6'b010000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    check("show_r0_lit", dp_if.bus_output, 3'b111); tick();

    // Add with wrap: 7 + 2 = 9 -> 001, carry set.
    drive("a_ld", 1'b0, 2'b00, 6'b010000, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0); tick();
    drive("add", 1'b0, 2'b00, 6'b000100, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0); tick();
    drive("add_out", 1'b0, 2'b00, 6'b000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    check("add_out_lit", dp_if.bus_output, 3'b001); tick();

    // Subtract and logic with A=111, bus=010.
    drive("sub", 1'b0, 2'b01, 6'b000100, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0); tick();
    drive("sub_out", 1'b0, 2'b00, 6'b000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    check("sub_out_lit", dp_if.bus_output, 3'b101); tick();
    drive("and", 1'b0, 2'b10, 6'b000100, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0); tick();
    drive("and_out", 1'b0, 2'b00, 6'b000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    check("and_out_lit", dp_if.bus_output, 3'b010); tick();
    drive("or", 1'b0, 2'b11, 6'b000100, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0); tick();
    drive("or_out", 1'b0, 2'b00, 6'b000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    check("or_out_lit", dp_if.bus_output, 3'b111); tick();

    // Borrow: A=010 minus bus=111 -> 011 with borrow.
    drive("a_ld2", 1'b0, 2'b00, 6'b000100, 1'b0, 3'b000, 1'b1, 1'b0, 1'b0); tick();
    drive("sub_b", 1'b0, 2'b01, 6'b010000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0); tick();
    drive("sub_b_out", 1'b0, 2'b00, 6'b000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    check("sub_b_lit", dp_if.bus_output, 3'b011); tick();

    // G_out with G_in: G <- A | G = 010 | 011 = 011.
    drive("g_self", 1'b0, 2'b11, 6'b000000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b1); tick();

    // Priority.
    drive("pri_data", 1'b0, 2'b00, 6'b010000, 1'b1, 3'b011, 1'b0, 1'b0, 1'b1);
    check("pri_data_lit", dp_if.bus_output, 3'b011); tick();
    drive("pri_g", 1'b0, 2'b00, 6'b010000, 1'b0, 3'b011, 1'b0, 1'b0, 1'b1);
    check("pri_g_lit", dp_if.bus_output, 3'b011); tick();
    drive("pri_none", 1'b0, 2'b00, 6'b000000, 1'b0, 3'b011, 1'b0, 1'b0, 1'b0);
    check("pri_none_lit", dp_if.bus_output, 3'b000); tick();

    // Reset mid-operation discards the R0 load; data still reaches the bus.
    drive("rst_mid", 1'b1, 2'b00, 6'b100000, 1'b1, 3'b101, 1'b0, 1'b0, 1'b0);
    check("rst_mid_lit", dp_if.bus_output, 3'b101); tick();
    drive("rm_r0", 1'b0, 2'b00, 6'b010000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    check("rm_r0_lit", dp_if.bus_output, 3'b000); tick();
    drive("rm_r1", 1'b0, 2'b00, 6'b000100, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    check("rm_r1_lit", dp_if.bus_output, 3'b000); tick();
    drive("rm_r2", 1'b0, 2'b00, 6'b000001, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    check("rm_r2_lit", dp_if.bus_output, 3'b000); tick();
    drive("rm_g", 1'b0, 2'b00, 6'b000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    check("rm_g_lit", dp_if.bus_output, 3'b000); tick();
    drive("rm_a", 1'b0, 2'b11, 6'b000000, 1'b0, 3'b000, 1'b0, 1'b1, 1'b0); tick();
    drive("rm_a_out", 1'b0, 2'b00, 6'b000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    check("rm_a_lit", dp_if.bus_output, 3'b000); tick();

    // Self transfer on R2.
    drive("ld_r2", 1'b0, 2'b00, 6'b000010, 1'b1, 3'b110, 1'b0, 1'b0, 1'b0); tick();
    for (int i = 0; i < 3; i++) begin
      drive("self_r2", 1'b0, 2'b00, 6'b000011, 1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
      check("self_r2_lit", dp_if.bus_output, 3'b110); tick();
    end

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive("rand", ($urandom_range(0, 19) == 0), 2'($urandom), 6'($urandom),
            ($urandom_range(0, 3) == 0), 3'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 2) == 0));
      tick();
    end

    drive("final", 1'b0, 2'b00, 6'b000000, 1'b0, 3'b000, 1'b0, 1'b0, 1'b1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule

// File: doc/datapath.md
# datapath

Three-bit single-bus register datapath: three general registers (R0–R2), an ALU operand register A and an ALU result register G, all sharing one combinational bus. An external controller sequences the per-register in/out strobes, the external data strobe and the ALU operation. The block sits under the simple-processor control FSM, and its bus is exported for display and debug.

## Interface
- No parameters; datapath width fixed at 3 bits, register count fixed at 3.
- clk  in  1  rising-edge clock for every register.
- rst  in  1  synchronous, active-high reset.
- op  in  2  ALU op: 00 add, 01 subtract, 10 AND, 11 OR.
- reg_sig  in  6  register strobes: [5] R0_in, [4] R0_out, [3] R1_in, [2] R1_out, [1] R2_in, [0] R2_out.
- data_in  in  1  drive `data` onto the bus.
- data  in  3  external data value.
- A_in  in  1  load A from the bus.
- G_in  in  1  load G with the ALU result.
- G_out  in  1  drive G onto the bus.
- bus_output  out  3  current bus value (combinational).
- carry_out  out  1  carry/borrow flag; present only with DATAPATH_CARRY_EN.

## Operation
- Bus source priority: data_in > G_out > R0_out > R1_out > R2_out.
- With no source asserted, the bus is 3'b000. There is no tri-state; the bus is a priority mux.
- bus_output always equals the bus.
- Rx_in loads Rx from the bus. Multiple Rx_in strobes may be active together; each loads the same bus value.
- A_in loads A from the bus.
- G_in loads G with f(A, bus), using A's pre-edge value:
  - 00: A+bus
  - 01: A−bus
  - 10: A&bus
  - 11: A|bus
- Arithmetic is modulo 8; results wrap silently.
- Same register driving the bus and loading in one cycle: it reloads its own value (no change).
- A_in and G_in together: G uses the old A, and A takes the bus.
- G_out and G_in together: G ← f(A, G).
- Outputs have no registered path: bus_output settles combinationally within the cycle.

## Timing
- Every storage element updates only on the rising edge of clk.
- Bus and bus_output follow strobe, data, op and register changes combinationally, with zero-cycle latency.
- A register loaded at edge N is visible on the bus (when selected) right after edge N.
- Load latency: strobe and value set up before edge N; the register holds the new value from edge N onward.
- Reset: R0, R1, R2, A and G all clear to 000 at the next rising edge while rst=1.
  - Reset overrides every load strobe in that cycle.
  - bus_output is then 000 unless a source is still asserted; data_in still passes `data`.
- Reset asserted mid-sequence discards that cycle's loads. Operation resumes on the first edge after rst falls.

## Configuration
- DATAPATH_CARRY_EN defined:
  - Adds a 1-bit flag register C and the carry_out port.
  - On G_in, C takes the carry-out of the add for op 00 or the borrow of the subtract for op 01. C clears for ops 10 and 11.
  - C resets to 0 with rst.
- DATAPATH_CARRY_EN undefined: no C register and no carry_out port; all other behaviour is identical.

## Test plan
- Load and display: reset, then:
  - data=010, reg_sig=001000, data_in=1 for one edge: R1=010.
  - data=111, reg_sig=100000, data_in=1: R0=111.
  - reg_sig=000100: bus_output=010.
  - reg_sig=010000: bus_output=111.
- Add with wrap: R0=111, R1=010. A_in with R0_out, then G_in with R1_out and op=00, then G_out: bus_output=001. With DATAPATH_CARRY_EN, carry_out=1.
- Subtract and logic, with A=111 and bus=010:
  - op=01 gives G=101.
  - op=10 gives G=010.
  - op=11 gives G=111.
  - Check each via G_out.
- Priority:
  - data=011, data_in=1, G_out=1, R0_out=1: bus_output=011.
  - Drop data_in: bus shows G.
  - No strobes: bus_output=000.
- Reset mid-operation: R0_in and data_in asserted with data=101 in the same cycle as rst=1. After the edge, R0=000 and all registers read back 000.
- Self transfer: R2=110, reg_sig=000011 across several edges: R2 stays 110 and bus_output=110.
